// File: rtl/vmem_arb_pkg.sv
// Shared types and constants for the vector-memory port B arbiter.
// Covers the arbiter state encoding and the read-return tag.
package vmem_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int MAX_RD_LAT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/vmem_rd_tag_pipe.sv
// Delay line that follows each accepted beat through the memory read latency.
// The tag tells the arbiter which requester owns the data on mem_q.
module vmem_rd_tag_pipe
    import vmem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t r_stage [DEPTH];

    // Clearing on reset drops every in-flight read return.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/vmem_port_arbiter.sv
// Round-robin arbiter sharing vector port B between the CPU load/store path (0)
// and the audio streaming engine (1), with burst locking and read-data routing.
module vmem_port_arbiter
    import vmem_arb_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 128,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req0_valid,
    input  logic              i_req0_we,
    input  logic              i_req0_last,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_wdata,
    output logic              o_req0_ready,
    output logic              o_req0_rvalid,
    output logic [DATA_W-1:0] o_req0_rdata,
    input  logic              i_req1_valid,
    input  logic              i_req1_we,
    input  logic              i_req1_last,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_wdata,
    output logic              o_req1_ready,
    output logic              o_req1_rvalid,
    output logic [DATA_W-1:0] o_req1_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_wren,
    input  logic [DATA_W-1:0] i_mem_q,
    output logic              o_busy
);

    arb_state_t r_state;
    logic       r_rrLast;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_accept;
    logic              w_selWe;
    logic              w_selLast;
    logic [ADDR_W-1:0] w_selAddr;
    logic [DATA_W-1:0] w_selWdata;
    rd_tag_t           w_tagIn;
    rd_tag_t           w_tagOut;

    // Grant is combinational so an accepted beat reaches memory in the same cycle.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (i_req0_valid && i_req1_valid) begin
                        w_gnt0 = r_rrLast;
                        w_gnt1 = !r_rrLast;
                    end else begin
                        w_gnt0 = i_req0_valid;
                        w_gnt1 = i_req1_valid;
                    end
                end
                OWN0:    w_gnt0 = i_req0_valid;
                OWN1:    w_gnt1 = i_req1_valid;
                default: ;
            endcase
        end
    end

    assign w_accept   = w_gnt0 | w_gnt1;
    assign w_selWe    = w_gnt1 ? i_req1_we    : i_req0_we;
    assign w_selLast  = w_gnt1 ? i_req1_last  : i_req0_last;
    assign w_selAddr  = w_gnt1 ? i_req1_addr  : i_req0_addr;
    assign w_selWdata = w_gnt1 ? i_req1_wdata : i_req0_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rrLast <= 1'b1;
        end else if (w_accept) begin
            if (w_selLast) begin
                r_state  <= IDLE;
                r_rrLast <= w_gnt1;
            end else begin
                r_state <= w_gnt1 ? OWN1 : OWN0;
            end
        end
    end

    assign o_req0_ready = w_gnt0;
    assign o_req1_ready = w_gnt1;
    assign o_busy       = (r_state != IDLE);

    assign o_mem_addr  = w_accept ? w_selAddr  : '0;
    assign o_mem_wdata = w_accept ? w_selWdata : '0;
    assign o_mem_wren  = w_accept & w_selWe;

    assign w_tagIn.valid = w_accept & !w_selWe;
    assign w_tagIn.owner = w_gnt1;

    vmem_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tagPipe (
        .clk   (clk),
        .reset (reset),
        .i_tag (w_tagIn),
        .o_tag (w_tagOut)
    );

    // Returns still leaving the pipe during a reset cycle are dropped.
    assign o_req0_rvalid = !reset & w_tagOut.valid & !w_tagOut.owner;
    assign o_req1_rvalid = !reset & w_tagOut.valid &  w_tagOut.owner;
    assign o_req0_rdata  = i_mem_q;
    assign o_req1_rdata  = i_mem_q;

endmodule

// File: tb/tb_vmem_port_arbiter.sv
// Randomized scoreboard bench for vmem_port_arbiter with a behavioural memory
// and a reference model built from the arbitration rules.
module tb_vmem_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 128;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req0_we, req0_last, req0_ready, req0_rvalid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata, req0_rdata;
    logic              req1_valid, req1_we, req1_last, req1_ready, req1_rvalid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata, req1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_q;
    logic              mem_wren, busy;

    always #5 clk = ~clk;

    vmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .i_req0_valid(req0_valid), .i_req0_we(req0_we), .i_req0_last(req0_last),
        .i_req0_addr(req0_addr), .i_req0_wdata(req0_wdata), .o_req0_ready(req0_ready),
        .o_req0_rvalid(req0_rvalid), .o_req0_rdata(req0_rdata),
        .i_req1_valid(req1_valid), .i_req1_we(req1_we), .i_req1_last(req1_last),
        .i_req1_addr(req1_addr), .i_req1_wdata(req1_wdata), .o_req1_ready(req1_ready),
        .o_req1_rvalid(req1_rvalid), .o_req1_rdata(req1_rdata),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wren(mem_wren),
        .i_mem_q(mem_q), .o_busy(busy)
    );

    typedef struct {
        logic              we;
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                gap;
    } beat_t;

    typedef struct {
        int                owner;
        logic [DATA_W-1:0] data;
        int                due;
    } rd_exp_t;

    beat_t   q0[$];
    beat_t   q1[$];
    rd_exp_t sbq[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      modelLock = -1;
    int      modelLast = 1;
    logic [DATA_W-1:0] shadow [1<<ADDR_W];

    function automatic logic [DATA_W-1:0] initWord(input logic [ADDR_W-1:0] a);
        return {8{a, 2'b10}};
    endfunction

    // Behavioural memory: stored XOR initWord so unwritten words are address-unique.
    logic [DATA_W-1:0] memArr [1<<ADDR_W] = '{default: '0};
    logic [DATA_W-1:0] rdPipe [RD_LAT] = '{default: '0};

    always @(posedge clk) begin
        if (mem_wren) memArr[mem_addr] <= mem_wdata ^ initWord(mem_addr);
        rdPipe[0] <= memArr[mem_addr] ^ initWord(mem_addr);
        for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign mem_q = rdPipe[RD_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic beat_t mkBeat(input logic we, input logic last,
                                     input logic [ADDR_W-1:0] addr,
                                     input logic [DATA_W-1:0] wdata, input int gap);
        beat_t b;
        b.we = we; b.last = last; b.addr = addr; b.wdata = wdata; b.gap = gap;
        return b;
    endfunction

    function automatic logic [DATA_W-1:0] rndWord();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic beat_t rndBeat();
        return mkBeat(1'($urandom), 1'($urandom), ADDR_W'($urandom), rndWord(), 0);
    endfunction

    // One clock cycle: drive the queue heads, check the combinational response
    // against the model, then advance the model past the clock edge.
    task automatic applyStimulus(input bit rst);
        bit    v0, v1;
        int    g;
        beat_t b0, b1, bg;
        @(posedge clk);
        #1;
        v0 = (q0.size() > 0) && (q0[0].gap == 0);
        v1 = (q1.size() > 0) && (q1[0].gap == 0);
        b0 = (q0.size() > 0) ? q0[0] : rndBeat();
        b1 = (q1.size() > 0) ? q1[0] : rndBeat();
        reset = rst;
        req0_valid = v0; req0_we = b0.we; req0_last = b0.last;
        req0_addr = b0.addr; req0_wdata = b0.wdata;
        req1_valid = v1; req1_we = b1.we; req1_last = b1.last;
        req1_addr = b1.addr; req1_wdata = b1.wdata;
        #1;
        g = -1;
        if (!rst) begin
            if (modelLock >= 0)   g = ((modelLock == 0) ? v0 : v1) ? modelLock : -1;
            else if (v0 && v1)    g = (modelLast == 0) ? 1 : 0;
            else if (v0)          g = 0;
            else if (v1)          g = 1;
        end
        bg = (g == 1) ? b1 : b0;
        checkOutput("req0_ready", req0_ready, g == 0);
        checkOutput("req1_ready", req1_ready, g == 1);
        checkOutput("busy", busy, modelLock != -1);
        checkOutput("mem_wren", mem_wren, (g >= 0) && bg.we);
        checkOutput("mem_addr", mem_addr, (g >= 0) ? bg.addr : '0);
        checkOutput("mem_wdata", mem_wdata, (g >= 0) ? bg.wdata : '0);
        if (!v0 && q0.size() > 0) q0[0].gap--;
        if (!v1 && q1.size() > 0) q1[0].gap--;
        if (rst) begin
            modelLock = -1;
            modelLast = 1;
            sbq.delete();
        end else if (g >= 0) begin
            if (bg.we) shadow[bg.addr] = bg.wdata;
            else       sbq.push_back('{g, shadow[bg.addr], cyc + RD_LAT});
            if (bg.last) begin
                modelLock = -1;
                modelLast = g;
            end else begin
                modelLock = g;
            end
            if (g == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
    endtask

    task automatic pushBurst(input int who, input int len, input logic we,
                             input logic [ADDR_W-1:0] base, input int gap0);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b = mkBeat(we, i == len - 1, base + ADDR_W'(i), rndWord(), (i == 0) ? gap0 : 0);
            if (who == 0) q0.push_back(b);
            else          q1.push_back(b);
        end
    endtask

    task automatic runDrain(input int maxCycles);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < maxCycles) begin
            applyStimulus(1'b0);
            n++;
        end
        for (int i = 0; i < RD_LAT + 2; i++) applyStimulus(1'b0);
    endtask

    // Read-return monitor, decoupled from stimulus through the scoreboard queue.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (req0_rvalid || req1_rvalid) begin
                if (sbq.size() == 0) begin
                    checkOutput("rvalid_unexpected", req0_rvalid | req1_rvalid, 0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("rvalid0", req0_rvalid, e.owner == 0);
                    checkOutput("rvalid1", req1_rvalid, e.owner == 1);
                    checkOutput("rvalid_cycle", cyc, e.due);
                    checkOutput("rdata0", req0_rdata, e.data);
                    checkOutput("rdata1", req1_rdata, e.data);
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                checkOutput("rvalid_missing", req0_rvalid | req1_rvalid, 1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) shadow[i] = initWord(ADDR_W'(i));
        reset = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_last = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_last = 1'b0; req1_addr = '0; req1_wdata = '0;
        applyStimulus(1'b1);
        applyStimulus(1'b1);

        // Single read from requester 0.
        pushBurst(0, 1, 1'b0, 14'h0010, 0);
        runDrain(20);

        // Tie after reset: both single-beat, alternating grants.
        applyStimulus(1'b1);
        pushBurst(0, 1, 1'b0, 14'h0011, 0);
        pushBurst(0, 1, 1'b1, 14'h0012, 0);
        pushBurst(1, 1, 1'b0, 14'h0013, 0);
        pushBurst(1, 1, 1'b1, 14'h0014, 0);
        runDrain(20);

        // Burst lock: requester 1 writes four beats while requester 0 waits.
        pushBurst(1, 4, 1'b1, 14'h0100, 0);
        pushBurst(0, 2, 1'b0, 14'h0101, 1);
        runDrain(30);

        // Bubble inside a requester 0 read burst.
        pushBurst(0, 3, 1'b0, 14'h0100, 0);
        q0[1].gap = 2;
        pushBurst(1, 1, 1'b0, 14'h0102, 1);
        runDrain(30);

        // Reset in the middle of a four-beat read burst.
        applyStimulus(1'b1);
        pushBurst(0, 4, 1'b0, 14'h0040, 0);
        pushBurst(1, 1, 1'b0, 14'h0041, 0);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        q0.delete();
        runDrain(20);

        // Mixed traffic: write then cross-requester read of the same word.
        q0.push_back(mkBeat(1'b1, 1'b1, 14'h0020, {16{8'hA5}}, 0));
        pushBurst(1, 1, 1'b0, 14'h0020, 2);
        runDrain(20);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if (q0.size() < 2 && $urandom_range(0, 3) == 0)
                pushBurst(0, $urandom_range(1, 4), 1'($urandom), 14'h0200 + ADDR_W'($urandom_range(0, 15)),
                          $urandom_range(0, 2));
            if (q1.size() < 2 && $urandom_range(0, 3) == 0)
                pushBurst(1, $urandom_range(1, 4), 1'($urandom), 14'h0200 + ADDR_W'($urandom_range(0, 15)),
                          $urandom_range(0, 2));
            if (q0.size() > 1 && $urandom_range(0, 7) == 0) q0[1].gap = $urandom_range(1, 2);
            if ($urandom_range(0, 127) == 0) begin
                applyStimulus(1'b1);
                q0.delete();
                q1.delete();
            end else begin
                applyStimulus(1'b0);
            end
        end
        runDrain(200);

        checkOutput("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
